alu: RTL and testbench

//  32-bit integer ALU for the RISC-V single-cycle/pipelined datapath execute stage.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_addsub.sv | 28 ++
 rtl/alu.sv | 75 +++++++
 tb/tb_alu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: operation codes and default datapath width.
// No logic of its own, so no latency and no flow control.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational shared adder for ADD/SUB: B is inverted and cin=1 when subtracting.
// Zero latency; no flow control.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

    assign o_sum   = w_full[WIDTH-1:0];
    assign o_carry = w_full[WIDTH];
    // Signed overflow: A and effective B share a sign that the sum does not.
    assign o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_full[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Execute-stage ALU (ADD/SUB/AND/OR) with registered result and flags; latency 1 clk.
// Free-running, one op per cycle, never stalls; valid_out is a delayed copy of valid_in.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALU_control,
    input  logic             valid_in,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             valid_out
);

    alu_op_t          w_op;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_carry;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;

    assign w_op = alu_op_t'(ALU_control);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a        (A),
        .i_b        (B),
        .i_sub      (w_op == ALU_SUB),
        .o_sum      (w_sum),
        .o_carry    (w_add_carry),
        .o_overflow (w_add_ovf)
    );

    always_comb begin
        w_result = w_sum;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (w_op)
            ALU_ADD, ALU_SUB: begin
                w_result = w_sum;
                w_carry  = w_add_carry;
                w_ovf    = w_add_ovf;
            end
            ALU_AND: w_result = A & B;
            ALU_OR:  w_result = A | B;
            default: w_result = w_sum;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            result    <= w_result;
            zero      <= (w_result == '0);
            negative  <= w_result[WIDTH-1];
            carry     <= w_carry;
            overflow  <= w_ovf;
            valid_out <= valid_in;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed + random bench for alu: expected results queued at drive time, popped after the capture edge.
module tb_alu;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
        logic         vld;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [1:0]   ALU_control;
    logic         valid_in;
    logic [W-1:0] result;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
    logic         valid_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .B           (B),
        .ALU_control (ALU_control),
        .valid_in    (valid_in),
        .result      (result),
        .zero        (zero),
        .negative    (negative),
        .carry       (carry),
        .overflow    (overflow),
        .valid_out   (valid_out)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour from unsigned comparisons and 64-bit signed range checks.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] op, input logic vin);
        exp_t   e;
        longint s;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            2'b00: begin
                e.res = a + b;
                e.c   = (e.res < a);
                s     = longint'($signed(a)) + longint'($signed(b));
                e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b01: begin
                e.res = a - b;
                e.c   = (a >= b);
                s     = longint'($signed(a)) - longint'($signed(b));
                e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b10:   e.res = a & b;
            default: e.res = a | b;
        endcase
        e.z   = (e.res == '0);
        e.n   = e.res[W-1];
        e.vld = vin;
        return e;
    endfunction

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_sb_empty: observed 0 entries expected 1", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_res"}, result, e.res);
        chk({tag, "_z"},   W'(zero),      W'(e.z));
        chk({tag, "_n"},   W'(negative),  W'(e.n));
        chk({tag, "_c"},   W'(carry),     W'(e.c));
        chk({tag, "_v"},   W'(overflow),  W'(e.v));
        chk({tag, "_vld"}, W'(valid_out), W'(e.vld));
    endtask

    // Called away from the rising edge; inputs captured on the next edge, checked 1 time unit later.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic vin);
        A           = a;
        B           = b;
        ALU_control = op;
        valid_in    = vin;
        sb_q.push_back(model(a, b, op, vin));
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res"}, result, '0);
        chk({tag, "_flags"}, W'({zero, negative, carry, overflow, valid_out}), '0);
    endtask

    initial begin
        rst = 1'b1;
        A = '0; B = '0; ALU_control = 2'b00; valid_in = 1'b0;
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        chk_all_zero("reset_held");
        @(negedge clk);
        rst = 1'b0;

        do_op("a2b3_add", 32'd2, 32'd3, 2'b00, 1'b1);
        chk("lit_add5", result, 32'd5);
        do_op("a2b3_sub", 32'd2, 32'd3, 2'b01, 1'b1);
        chk("lit_sub_m1", result, 32'hFFFF_FFFF);
        chk("lit_sub_nc", W'({negative, carry}), W'(2'b10));
        do_op("a2b3_and", 32'd2, 32'd3, 2'b10, 1'b1);
        chk("lit_and2", result, 32'd2);
        do_op("a2b3_or",  32'd2, 32'd3, 2'b11, 1'b1);
        chk("lit_or3", result, 32'd3);

        do_op("a5b4_add", 32'd5, 32'd4, 2'b00, 1'b1);
        do_op("a5b4_sub", 32'd5, 32'd4, 2'b01, 1'b1);
        chk("lit_sub1_cz", W'({carry, zero}), W'(2'b10));
        do_op("a5b4_and", 32'd5, 32'd4, 2'b10, 1'b1);
        do_op("a5b4_or",  32'd5, 32'd4, 2'b11, 1'b1);

        do_op("eq_sub", 32'h1234, 32'h1234, 2'b01, 1'b1);
        chk("lit_eq_zcv", W'({zero, carry, overflow}), W'(3'b110));
        do_op("ovf_add", 32'h7FFF_FFFF, 32'd1, 2'b00, 1'b1);
        chk("lit_ovf_vnc", W'({overflow, negative, carry}), W'(3'b110));
        do_op("wrap_add", 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b1);
        chk("lit_wrap_czv", W'({carry, zero, overflow}), W'(3'b110));
        do_op("ovf_sub", 32'h8000_0000, 32'd1, 2'b01, 1'b1);

        // Async reset between edges must clear outputs before any clock edge.
        A = 32'd7; B = 32'd9; ALU_control = 2'b00; valid_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        chk_all_zero("async_rst_held");
        @(negedge clk);
        rst = 1'b0;
        do_op("post_rst_add", 32'd2, 32'd3, 2'b00, 1'b1);
        chk("lit_post_rst5", result, 32'd5);

        do_op("vld_1", 32'd10, 32'd20, 2'b00, 1'b1);
        do_op("vld_0", 32'd11, 32'd20, 2'b00, 1'b0);
        chk("lit_vld0_res", result, 32'd31);
        do_op("vld_1b", 32'd12, 32'd20, 2'b00, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom();
            rb = (i % 5 == 0) ? ra : $urandom();
            do_op("rand", ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
